// File: rtl/intr_ctl.sv
// intr_ctl: external edge/level lines, reloadable timers, a clock
// comparator and a software interrupt merged into one masked line.
module intr_ctl #(
  parameter int NEXT   = 4,
  parameter int NTIMER = 2,
  parameter int TW     = 24
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NEXT-1:0] ext_intr,
  output logic            interrupt,
  input  logic            io_write,
  input  logic [4:0]      io_addr,
  input  logic [15:0]     io_wdata,
  output logic [15:0]     io_rdata
);

  localparam int NS = NEXT + NTIMER + 2;
  localparam int CI = NEXT + NTIMER;

  logic [NS-1:0]     lat, lat_nx, en;
  logic [NS-1:0]     hw_ev, status, pend, mode_full;
  logic [NEXT-1:0]   mode, hist;
  logic [NTIMER-1:0] run, oneshot, tev;
  logic [31:0]       ccnt, ccmp;
  logic [TW-1:0]     tcnt [NTIMER];
  logic [TW-1:0]     trld [NTIMER];
  logic [3:0]        vidx;

  logic w_en, w_mode, w_set, w_clr, w_tctl;
  logic w_clo, w_chi, w_mlo, w_mhi;
  logic [NTIMER-1:0] w_tclo, w_tchi, w_trlo, w_trhi;

  always_comb begin
    w_en   = io_write && io_addr == 5'd2;
    w_mode = io_write && io_addr == 5'd3;
    w_set  = io_write && io_addr == 5'd4;
    w_clr  = io_write && io_addr == 5'd5;
    w_tctl = io_write && io_addr == 5'd7;
    w_clo  = io_write && io_addr == 5'd8;
    w_chi  = io_write && io_addr == 5'd9;
    w_mlo  = io_write && io_addr == 5'd10;
    w_mhi  = io_write && io_addr == 5'd11;
    for (int t = 0; t < NTIMER; t++) begin
      w_tclo[t] = io_write && io_addr == 5'(16 + 4*t);
      w_tchi[t] = io_write && io_addr == 5'(17 + 4*t);
      w_trlo[t] = io_write && io_addr == 5'(18 + 4*t);
      w_trhi[t] = io_write && io_addr == 5'(19 + 4*t);
    end
  end

  always_comb begin
    for (int t = 0; t < NTIMER; t++)
      tev[t] = run[t] && tcnt[t] == '0;
  end

  always_comb begin
    mode_full = '1;
    mode_full[NEXT-1:0] = mode;
    hw_ev = '0;
    hw_ev[NEXT-1:0] = ext_intr & ~hist & mode;
    hw_ev[CI-1:NEXT] = tev;
    hw_ev[CI] = ccnt == ccmp;
    status = lat;
    for (int i = 0; i < NEXT; i++)
      if (!mode[i]) status[i] = ext_intr[i];
    pend = en & status;
  end

  assign interrupt = |pend;

  // hardware event beats clear beats set; level sources keep no latch
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      lat_nx[i] = lat[i];
      if (hw_ev[i])
        lat_nx[i] = 1'b1;
      else if (w_clr && io_wdata[i])
        lat_nx[i] = 1'b0;
      else if (w_set && io_wdata[i])
        lat_nx[i] = 1'b1;
      if (!mode_full[i]) lat_nx[i] = 1'b0;
    end
  end

  always_comb begin
    vidx = '0;
    for (int i = NS - 1; i >= 0; i--)
      if (pend[i]) vidx = 4'(i);
  end

  always_comb begin
    io_rdata = '0;
    case (io_addr)
      5'd0:    io_rdata = 16'(pend);
      5'd1:    io_rdata = 16'(status);
      5'd2:    io_rdata = 16'(en);
      5'd3:    io_rdata = 16'(mode_full);
      5'd6:    io_rdata = {|pend, 11'd0, vidx};
      5'd7:    io_rdata = {8'(oneshot), 8'(run)};
      5'd8:    io_rdata = ccnt[15:0];
      5'd9:    io_rdata = ccnt[31:16];
      5'd10:   io_rdata = ccmp[15:0];
      5'd11:   io_rdata = ccmp[31:16];
      default: io_rdata = '0;
    endcase
    for (int t = 0; t < NTIMER; t++) begin
      if (io_addr == 5'(16 + 4*t)) io_rdata = tcnt[t][15:0];
      if (io_addr == 5'(17 + 4*t)) io_rdata = 16'(tcnt[t][TW-1:16]);
      if (io_addr == 5'(18 + 4*t)) io_rdata = trld[t][15:0];
      if (io_addr == 5'(19 + 4*t)) io_rdata = 16'(trld[t][TW-1:16]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat     <= '0;
      en      <= '0;
      mode    <= '0;
      hist    <= '0;
      run     <= '0;
      oneshot <= '0;
      ccnt    <= '0;
      ccmp    <= '1;
    end else begin
      lat  <= lat_nx;
      hist <= ext_intr;
      if (w_en)   en   <= io_wdata[NS-1:0];
      if (w_mode) mode <= io_wdata[NEXT-1:0];
      if (w_tctl) begin
        run     <= io_wdata[NTIMER-1:0];
        oneshot <= io_wdata[8 +: NTIMER];
      end else begin
        run <= run & ~(tev & oneshot);
      end
      if (w_clo)
        ccnt[15:0] <= io_wdata;
      else if (w_chi)
        ccnt[31:16] <= io_wdata;
      else
        ccnt <= ccnt + 32'd1;
      if (w_mlo) ccmp[15:0]  <= io_wdata;
      if (w_mhi) ccmp[31:16] <= io_wdata;
    end
  end

  // a reload-hi write restarts the count from the new full reload
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int t = 0; t < NTIMER; t++) begin
        tcnt[t] <= '0;
        trld[t] <= '0;
      end
    end else begin
      for (int t = 0; t < NTIMER; t++) begin
        if (w_trlo[t]) trld[t][15:0] <= io_wdata;
        if (w_trhi[t]) trld[t][TW-1:16] <= io_wdata[TW-17:0];
        if (w_tclo[t])
          tcnt[t][15:0] <= io_wdata;
        else if (w_tchi[t])
          tcnt[t][TW-1:16] <= io_wdata[TW-17:0];
        else if (w_trhi[t])
          tcnt[t] <= {io_wdata[TW-17:0], trld[t][15:0]};
        else if (tev[t])
          tcnt[t] <= trld[t];
        else if (run[t])
          tcnt[t] <= tcnt[t] - TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_intr_ctl.sv
// tb_intr_ctl: directed tests for intr_ctl with NEXT=4, NTIMER=2.
// Sources: ext 0..3, timers 4..5, clock 6, swi 7.
module tb_intr_ctl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  ext_intr = '0;
  logic        interrupt;
  logic        io_write = 1'b0;
  logic [4:0]  io_addr = '0;
  logic [15:0] io_wdata = '0;
  logic [15:0] io_rdata;
  logic [15:0] d;
  int total = 0;
  int bad = 0;

  intr_ctl #(.NEXT(4), .NTIMER(2), .TW(24)) dut (
    .clk(clk),
    .reset(reset),
    .ext_intr(ext_intr),
    .interrupt(interrupt),
    .io_write(io_write),
    .io_addr(io_addr),
    .io_wdata(io_wdata),
    .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [4:0] a, input logic [15:0] v);
    @(negedge clk);
    io_write = 1'b1;
    io_addr = a;
    io_wdata = v;
    @(negedge clk);
    io_write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [15:0] v);
    io_addr = a;
    #1;
    v = io_rdata;
  endtask

  task automatic test_reset;
    logic [15:0] e;
    #1;
    for (int a = 0; a < 32; a++) begin
      e = (a == 3) ? 16'h00F0 : (a == 10 || a == 11) ? 16'hFFFF : 16'h0;
      rd(5'(a), d);
      total++;
      if (d !== e) begin
        bad++;
        $display("FAIL reset_reg%0d got=%h exp=%h", a, d, e);
      end
    end
    total++;
    if (interrupt !== 1'b0) begin
      bad++;
      $display("FAIL reset_irq got=%b exp=0", interrupt);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_edge;
    wr(3, 16'h0001);
    wr(2, 16'h0001);
    @(negedge clk);
    ext_intr[0] = 1'b1;
    rd(0, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL edge_early got=%h exp=0000", d);
    end
    @(negedge clk);
    rd(0, d);
    total++;
    if (d !== 16'h0001 || interrupt !== 1'b1) begin
      bad++; $display("FAIL edge_set got=%h/%b exp=0001/1", d, interrupt);
    end
    repeat (2) @(negedge clk);
    ext_intr[0] = 1'b0;
    repeat (2) @(negedge clk);
    rd(0, d);
    total++;
    if (d !== 16'h0001) begin
      bad++; $display("FAIL edge_hold got=%h exp=0001", d);
    end
    rd(6, d);
    total++;
    if (d !== 16'h8000) begin
      bad++; $display("FAIL edge_vec got=%h exp=8000", d);
    end
    wr(5, 16'h0001);
    rd(0, d);
    total++;
    if (d !== 16'h0000 || interrupt !== 1'b0) begin
      bad++; $display("FAIL edge_clr got=%h/%b exp=0000/0", d, interrupt);
    end
    @(negedge clk);
    ext_intr[0] = 1'b1;
    @(negedge clk);
    wr(5, 16'h0001);
    repeat (3) @(negedge clk);
    rd(0, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL edge_noretrig got=%h exp=0000", d);
    end
    ext_intr[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_level;
    wr(2, 16'h0002);
    @(negedge clk);
    ext_intr[1] = 1'b1;
    #1;
    total++;
    if (interrupt !== 1'b1) begin
      bad++; $display("FAIL level_irq got=%b exp=1", interrupt);
    end
    wr(5, 16'h0002);
    rd(0, d);
    total++;
    if (d !== 16'h0002) begin
      bad++; $display("FAIL level_clr got=%h exp=0002", d);
    end
    @(negedge clk);
    ext_intr[1] = 1'b0;
    #1;
    total++;
    if (interrupt !== 1'b0) begin
      bad++; $display("FAIL level_drop got=%b exp=0", interrupt);
    end
    wr(4, 16'h0002);
    rd(1, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL level_set got=%h exp=0000", d);
    end
  endtask

  task automatic test_timer;
    wr(2, 16'h0010);
    wr(18, 16'h0003);
    wr(19, 16'h0000);
    wr(7, 16'h0001);
    rd(16, d);
    total++;
    if (d !== 16'h0003) begin
      bad++; $display("FAIL tmr_load got=%h exp=0003", d);
    end
    repeat (3) @(negedge clk);
    rd(16, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL tmr_zero got=%h exp=0000", d);
    end
    rd(0, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL tmr_early got=%h exp=0000", d);
    end
    @(negedge clk);
    rd(0, d);
    total++;
    if (d !== 16'h0010 || interrupt !== 1'b1) begin
      bad++; $display("FAIL tmr_event got=%h/%b exp=0010/1", d, interrupt);
    end
    rd(6, d);
    total++;
    if (d !== 16'h8004) begin
      bad++; $display("FAIL tmr_vec got=%h exp=8004", d);
    end
    rd(16, d);
    total++;
    if (d !== 16'h0003) begin
      bad++; $display("FAIL tmr_reload got=%h exp=0003", d);
    end
    wr(5, 16'h0010);
    repeat (3) @(negedge clk);
    rd(0, d);
    total++;
    if (d !== 16'h0010) begin
      bad++; $display("FAIL tmr_period got=%h exp=0010", d);
    end
    wr(7, 16'h0000);
    wr(16, 16'h0002);
    wr(5, 16'h0010);
    wr(7, 16'h0101);
    repeat (2) @(negedge clk);
    rd(0, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL os_early got=%h exp=0000", d);
    end
    @(negedge clk);
    rd(0, d);
    total++;
    if (d !== 16'h0010) begin
      bad++; $display("FAIL os_event got=%h exp=0010", d);
    end
    rd(7, d);
    total++;
    if (d !== 16'h0100) begin
      bad++; $display("FAIL os_run got=%h exp=0100", d);
    end
    wr(5, 16'h0010);
    repeat (8) @(negedge clk);
    rd(0, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL os_once got=%h exp=0000", d);
    end
    rd(16, d);
    total++;
    if (d !== 16'h0003) begin
      bad++; $display("FAIL os_hold got=%h exp=0003", d);
    end
  endtask

  task automatic test_clock;
    wr(2, 16'h0040);
    wr(11, 16'h0000);
    wr(10, 16'h0010);
    wr(9, 16'h0000);
    @(negedge clk);
    io_write = 1'b1;
    io_addr = 5'd8;
    io_wdata = 16'h0000;
    @(negedge clk);
    io_addr = 5'd5;
    io_wdata = 16'h0040;
    @(negedge clk);
    io_write = 1'b0;
    repeat (15) @(negedge clk);
    rd(8, d);
    total++;
    if (d !== 16'h0010) begin
      bad++; $display("FAIL clk_count got=%h exp=0010", d);
    end
    rd(0, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL clk_early got=%h exp=0000", d);
    end
    io_write = 1'b1;
    io_addr = 5'd5;
    io_wdata = 16'h0040;
    @(negedge clk);
    io_write = 1'b0;
    rd(0, d);
    total++;
    if (d !== 16'h0040) begin
      bad++; $display("FAIL clk_ev_vs_clr got=%h exp=0040", d);
    end
    wr(5, 16'h0040);
    rd(0, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL clk_clr got=%h exp=0000", d);
    end
  endtask

  task automatic test_vector;
    wr(2, 16'h0081);
    @(negedge clk);
    ext_intr[0] = 1'b1;
    @(negedge clk);
    ext_intr[0] = 1'b0;
    wr(4, 16'h0080);
    rd(0, d);
    total++;
    if (d !== 16'h0081) begin
      bad++; $display("FAIL vec_pend got=%h exp=0081", d);
    end
    rd(6, d);
    total++;
    if (d !== 16'h8000) begin
      bad++; $display("FAIL vec_low got=%h exp=8000", d);
    end
    wr(5, 16'h0001);
    rd(6, d);
    total++;
    if (d !== 16'h8007) begin
      bad++; $display("FAIL vec_swi got=%h exp=8007", d);
    end
    wr(5, 16'h0080);
    rd(6, d);
    total++;
    if (d !== 16'h0000 || interrupt !== 1'b0) begin
      bad++; $display("FAIL vec_none got=%h/%b exp=0000/0", d, interrupt);
    end
  endtask

  task automatic test_reset_mid;
    wr(2, 16'h0010);
    wr(18, 16'h0000);
    wr(19, 16'h0000);
    wr(7, 16'h0001);
    @(negedge clk);
    rd(0, d);
    total++;
    if (d !== 16'h0010) begin
      bad++; $display("FAIL mid_event got=%h exp=0010", d);
    end
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (interrupt !== 1'b0) begin
      bad++; $display("FAIL mid_irq got=%b exp=0", interrupt);
    end
    rd(7, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL mid_tctl got=%h exp=0000", d);
    end
    rd(10, d);
    total++;
    if (d !== 16'hFFFF) begin
      bad++; $display("FAIL mid_cmp got=%h exp=FFFF", d);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    rd(1, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL mid_status got=%h exp=0000", d);
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_level();
    test_timer();
    test_clock();
    test_vector();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/intr_ctl.md
Name: intr_ctl

Overview:
- Parametrised successor to the fixed 5-source interrupt/timer block.
- Collects NEXT external interrupt lines, NTIMER reloadable down-counters, one 32-bit free-running clock comparator and one software interrupt into a single masked interrupt line.
- Adds per-source edge/level mode, one-shot or periodic timers, and a priority vector register.
- Sits on the 16-bit io bus next to the uart and sd blocks; its interrupt output drives the CPU.

Parameters:
- NEXT, 4, number of external sources; NEXT+NTIMER+2 <= 16.
- NTIMER, 2, number of timers, 1..4.
- TW, 24, timer width, 17..32.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ext_intr  in  NEXT  external requests, synchronous to clk.
- interrupt  out  1  high when any enabled source is pending.
- io_write  in  1  write strobe, one cycle per write.
- io_addr  in  5  word register address.
- io_wdata  in  16  write data.
- io_rdata  out  16  read data, combinational from io_addr.

Behaviour:
- Source index map:
  - [NEXT-1:0] external sources.
  - NEXT+t for timer t.
  - NEXT+NTIMER for the clock comparator.
  - NEXT+NTIMER+1 for the software interrupt (swi).
  - Unused bits up to 15 read 0.
- Register map:
  - 0 pending, read-only: enable & status.
  - 1 status, read-only.
  - 2 enable, read/write.
  - 3 mode, read/write: 1=edge, 0=level. Only external bits are writable; internal bits read 1.
  - 4 set, write-1-to-set on latches.
  - 5 clear, write-1-to-clear on latches.
  - 6 vector, read-only: bit15 = any pending; [3:0] = lowest-numbered pending index; 0 if none.
  - 7 tctl: bit t = timer run; bit 8+t = one-shot.
  - 8/9 clock count lo/hi; 10/11 clock compare lo/hi.
  - 16+4t..19+4t: timer t count lo, count hi, reload lo, reload hi.
  - All other addresses read 16'h0; writes to them are ignored.
- Status per source:
  - Level-mode external: status = live ext_intr; no latch; set/clear have no effect.
  - Edge-mode external: a latch is set by a rising edge (ext_intr high now, low in the previous cycle).
  - Timer, clock and swi sources are always latched.
  - A latch is set in the cycle after its event and stays set until cleared.
- Priority per latch, per cycle: hardware event > clear write > set write. A hardware event in the same cycle as a clear write leaves the latch set.
- interrupt = |pending, combinational from latches, enable and level inputs. No added latency beyond the latch.
- Clock counter:
  - 32-bit, increments every cycle and wraps at 2^32-1 -> 0.
  - A write to lo or hi replaces that half in place of that cycle's increment.
  - When count == compare, the clock latch is set; this repeats every cycle while equal.
- Timer t, TW bits:
  - Counts down only while run=1; holds its value while run=0.
  - When running and count==0, the next cycle sets the latch and reloads count from reload.
  - In one-shot mode the same cycle also clears run.
  - A write to reload hi loads the full TW-bit reload into count, including the new hi bits. Hi writes use bits [TW-17:0].
  - A count write overrides decrement and reload in that cycle.
  - Reload=0 while running gives a latch event every cycle.
- Reads of fields wider or narrower than 16 bits are zero-padded.
- Reset (reset low, asynchronous):
  - Latches, enable, mode, tctl, clock count, timer counts and reloads all go to 0.
  - Clock compare goes to 32'hFFFF_FFFF.
  - The edge-detect history register goes to 0.
  - interrupt=0. io_rdata follows io_addr against the reset values.
  - Reset mid-count aborts all state with no pending event; release takes effect on the next clk edge.

Test Plan:
- Reset, then read all registers -> 0, except clock compare reading FFFF/FFFF and mode bits [7:4] reading 1; interrupt=0.
- Mode[0]=1, enable[0]=1, pulse ext_intr[0] high for 3 cycles -> pending[0] set once and held after the input drops; vector=8000; write clear=0001 -> interrupt falls.
- Mode[1]=0, enable[1]=1, ext_intr[1] high -> interrupt high in the same cycle. Drop the input -> interrupt low. Clear write has no effect.
- Timer0: reload=3, tctl=0001, enable[4]=1 -> latch every 4 cycles; vector=8004. Set tctl=0101 -> one event, then run bit reads 0.
- Clock: compare=0000_0010, count=0 -> latch set on cycle 16. A clear write in that same cycle -> latch stays set.
- ext0 and swi pending, both enabled -> vector=8000; clear bit0 -> vector=8007.
